// File: rtl/ftf_decoder_42_pipe_pkg.sv
// Shared constants for the 42-wire FTF codec: Fibonacci numeral system weights,
// group partitioning of the codeword and the decoded data width.
package ftf_decoder_42_pipe_pkg;

    localparam int unsigned FTF42_CODE_W = 42;
    localparam int unsigned FTF42_GRP_W  = 7;
    localparam int unsigned FTF42_NGRP   = 6;
    // floor(log2(FNS44)): widest binary value every codeword range can hold
    localparam int unsigned FBLEN42      = 29;

    // FNS(n): Fibonacci numeral system weight, FNS01 = FNS02 = 1
    function automatic logic [63:0] fns(input int unsigned n);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t;
        a = 64'd1;
        b = 64'd1;
        for (int unsigned k = 3; k <= n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Weight of codeword bit i: bit0 is 1, bit i is FNS(i+1)
    function automatic logic [63:0] ftf42_weight(input int unsigned i);
        return (i == 0) ? 64'd1 : fns(i + 1);
    endfunction

endpackage

// File: rtl/ftf_group_sum7.sv
// Combinational weighted sum of one 7-bit slice of an FTF codeword whose
// lowest bit sits at codeword position BASE.
module ftf_group_sum7
    import ftf_decoder_42_pipe_pkg::*;
#(
    parameter int unsigned BASE  = 0,
    parameter int unsigned SUM_W = FBLEN42 + 1
) (
    input  logic [FTF42_GRP_W-1:0] bits,
    output logic [SUM_W-1:0]       sum_c
);

    logic [SUM_W-1:0] term [FTF42_GRP_W];

    for (genvar j = 0; j < FTF42_GRP_W; j++) begin : g_term
        localparam logic [SUM_W-1:0] WEIGHT = SUM_W'(ftf42_weight(BASE + j));
        assign term[j] = bits[j] ? WEIGHT : '0;
    end

    always_comb begin
        sum_c = '0;
        for (int j = 0; j < FTF42_GRP_W; j++) begin
            sum_c = sum_c + term[j];
        end
    end

endmodule

// File: rtl/ftf_decoder_42_pipe.sv
// 3-stage FTF-42 codeword to binary decoder with valid/ready and full stall.
// Optional FTF_RANGE_CHECK_EN adds range_err, the sum bit above dataout.
module ftf_decoder_42_pipe
    import ftf_decoder_42_pipe_pkg::*;
#(
    parameter int unsigned CODE_W = FTF42_CODE_W,
    parameter int unsigned DATA_W = FBLEN42
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] codein,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready
`ifdef FTF_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);

`ifdef FTF_RANGE_CHECK_EN
    localparam int unsigned SUM_W = DATA_W + 1;
`else
    // Without the check the overflow bit is never observed, so it is not built
    localparam int unsigned SUM_W = DATA_W;
`endif

    logic              en_c;
    logic [CODE_W-1:0] code_q;
    logic              v1;
    logic              v2;
    logic [SUM_W-1:0]  part_c [FTF42_NGRP];
    logic [SUM_W-1:0]  part_q [FTF42_NGRP];
    logic [SUM_W-1:0]  total_c;

    assign en_c     = out_ready | ~out_valid;
    assign in_ready = en_c;

    // S1: capture codeword
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q <= '0;
            v1     <= 1'b0;
        end else if (en_c) begin
            code_q <= codein;
            v1     <= in_valid;
        end
    end

    for (genvar g = 0; g < FTF42_NGRP; g++) begin : g_grp
        ftf_group_sum7 #(
            .BASE  (g * FTF42_GRP_W),
            .SUM_W (SUM_W)
        ) u_sum (
            .bits  (code_q[g*FTF42_GRP_W +: FTF42_GRP_W]),
            .sum_c (part_c[g])
        );
    end

    // S2: register group partial sums
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < FTF42_NGRP; g++) begin
                part_q[g] <= '0;
            end
            v2 <= 1'b0;
        end else if (en_c) begin
            for (int g = 0; g < FTF42_NGRP; g++) begin
                part_q[g] <= part_c[g];
            end
            v2 <= v1;
        end
    end

    always_comb begin
        total_c = '0;
        for (int g = 0; g < FTF42_NGRP; g++) begin
            total_c = total_c + part_q[g];
        end
    end

    // S3: final sum and output valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dataout   <= '0;
            out_valid <= 1'b0;
`ifdef FTF_RANGE_CHECK_EN
            range_err <= 1'b0;
`endif
        end else if (en_c) begin
            dataout   <= total_c[DATA_W-1:0];
            out_valid <= v2;
`ifdef FTF_RANGE_CHECK_EN
            range_err <= total_c[DATA_W];
`endif
        end
    end

endmodule

// File: tb/tb_ftf_decoder_42_pipe.sv
// Directed bench for ftf_decoder_42_pipe: latency, one-hot weights, backpressure,
// async reset, range check and greedy-encoded round trips against a scoreboard.
module tb_ftf_decoder_42_pipe;
    import ftf_decoder_42_pipe_pkg::*;

    localparam int unsigned DW = FBLEN42;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [41:0]   codein;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dataout;
    logic          out_valid;
    logic          out_ready;
`ifdef FTF_RANGE_CHECK_EN
    logic          range_err;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [63:0]   sb_d [$];
    logic          sb_r [$];
    logic [63:0]   wt [42];
    logic [63:0]   bp_v [5] = '{64'd12345, 64'd536870911, 64'd7, 64'd99999999, 64'd1000};
    logic [63:0]   rs_v [3] = '{64'd4242, 64'd31337, 64'd271828};
    logic [63:0]   hold;
    logic [63:0]   v;
    logic          a;

    ftf_decoder_42_pipe dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .codein    (codein),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FTF_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy FTF encoder (largest weight first)
    function automatic logic [41:0] encode(input logic [63:0] val);
        logic [41:0] c;
        logic [63:0] r;
        c = '0;
        r = val;
        for (int i = 41; i >= 1; i--) begin
            if (r >= wt[i]) begin
                c[i] = 1'b1;
                r    = r - wt[i];
            end
        end
        c[0] = r[0];
        return c;
    endfunction

    // One clock: drive at negedge, score output transfer, record input transfer
    task automatic tick(input logic iv, input logic [41:0] c, input logic ordy,
                        input logic [63:0] exp_d, input logic exp_r, output logic acc);
        @(negedge clock);
        in_valid  = iv;
        codein    = c;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sb_d.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                check("dataout", 64'(dataout), sb_d.pop_front());
`ifdef FTF_RANGE_CHECK_EN
                check("range_err", 64'(range_err), 64'(sb_r.pop_front()));
`else
                void'(sb_r.pop_front());
`endif
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            sb_d.push_back(exp_d);
            sb_r.push_back(exp_r);
        end
    endtask

    task automatic idle(input logic ordy);
        logic x;
        tick(1'b0, '0, ordy, 64'd0, 1'b0, x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_d.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 64'(sb_d.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wt[0] = 64'd1;
        wt[1] = 64'd1;
        for (int i = 2; i < 42; i++) wt[i] = wt[i-1] + wt[i-2];

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        codein    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dataout",   64'(dataout),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef FTF_RANGE_CHECK_EN
        check("rst_range_err", 64'(range_err), 64'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        // Zero codeword, three-clock latency
        tick(1'b1, 42'd0, 1'b1, 64'd0, 1'b0, a);
        idle(1'b1); check("lat_c1", 64'(out_valid), 64'd0);
        idle(1'b1); check("lat_c2", 64'(out_valid), 64'd0);
        idle(1'b1); check("lat_c3", 64'(out_valid), 64'd1);
        idle(1'b1); check("lat_gone", 64'(out_valid), 64'd0);

        // One-hot weights, back to back
        tick(1'b1, 42'h1,       1'b1, 64'd1,         1'b0, a);
        tick(1'b1, 42'h1 << 1,  1'b1, 64'd1,         1'b0, a);
        tick(1'b1, 42'h1 << 20, 1'b1, 64'd10946,     1'b0, a);
        tick(1'b1, 42'h1 << 41, 1'b1, 64'd267914296, 1'b0, a);
        check("b2b_first", 64'(out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("b2b_next", 64'(out_valid), 64'd1);
        end
        idle(1'b1);
        check("b2b_end", 64'(out_valid), 64'd0);

        // Backpressure: 4-clock stall once the first word reaches the output
        for (int k = 0; k < 3; k++) tick(1'b1, encode(bp_v[k]), 1'b1, bp_v[k], 1'b0, a);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, encode(bp_v[3]), 1'b0, bp_v[3], 1'b0, a);
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            if (k == 0) hold = 64'(dataout);
            else check("stall_hold", 64'(dataout), hold);
        end
        for (int k = 3; k < 5; ) begin
            tick(1'b1, encode(bp_v[k]), 1'b1, bp_v[k], 1'b0, a);
            if (a) k++;
        end
        drain();

        // Asynchronous reset with three words in flight
        for (int k = 0; k < 3; k++) tick(1'b1, encode(rs_v[k]), 1'b1, rs_v[k], 1'b0, a);
        idle(1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data",  64'(dataout),   64'd0);
`ifdef FTF_RANGE_CHECK_EN
        check("async_rst_range", 64'(range_err), 64'd0);
`endif
        sb_d.delete();
        sb_r.delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end

        // All-ones overflows DATA_W; largest representable value does not
        tick(1'b1, {42{1'b1}}, 1'b1, 64'd164537820, 1'b1, a);
        tick(1'b1, encode(64'd536870911), 1'b1, 64'd536870911, 1'b0, a);
        drain();

        // Round trip with random bubbles and backpressure
        for (int n = 0; n < 2000; n++) begin
            int t;
            v = 64'($urandom & 32'h1FFF_FFFF);
            if ($urandom_range(0, 7) == 0) idle(($urandom_range(0, 3) != 0));
            t = 0;
            a = 1'b0;
            while (!a && t < 100) begin
                tick(1'b1, encode(v), ($urandom_range(0, 3) != 0), v, 1'b0, a);
                t++;
            end
            if (!a) check("accept_timeout", 64'(a), 64'd1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ftf_decoder_42_pipe.md
Name: ftf_decoder_42_pipe

Overview:
- Receive-side counterpart of the 42-wire FTF encoder: maps a 42-bit FTF codeword back to its FBLEN42-bit binary value using the Fibonacci-numeral-system weights from FNS.vh.
- Sits at the far end of the coded bus, directly after the bus-capture register.
- 3-stage pipeline with a valid/ready handshake on both sides and full-pipeline stall on backpressure.

Parameters:
- CODE_W, 42, codeword width; 42 is the only legal value.
- DATA_W, `FBLEN42, decoded data width.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- codein  input  CODE_W  FTF codeword
- in_valid  input  1  codein is valid this cycle
- in_ready  output  1  decoder accepts codein this cycle
- dataout  output  DATA_W  decoded value
- out_valid  output  1  dataout is valid
- out_ready  input  1  downstream accepts dataout
- range_err  output  1  decoded sum exceeded DATA_W; present only with FTF_RANGE_CHECK_EN

Behaviour:
- Weights: bit0 has weight 1; bit i (1..41) has weight `FNS(i+1)`, so bit1 = FNS02 and bit41 = FNS42. dataout = code[0] + sum of code[i]*FNS(i+1). This is the exact inverse of the encoder's subtract chain.
- Arithmetic: all sums are carried in DATA_W+1 bits. dataout is the low DATA_W bits.
- Stage S1: register codein and v1.
- Stage S2: six 7-bit groups (bits 0-6, 7-13, 14-20, 21-27, 28-34, 35-41). Each group produces one weighted partial sum. Register the partials and v2.
- Stage S3: add the six partials, register dataout and out_valid (v3).
- Latency: exactly 3 clocks from an accepted input to out_valid, when out_ready is held high.
- Stall: enable = out_ready | ~out_valid. All stage registers and valid bits update only when enable=1. in_ready = enable (combinational).
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - A bubble enters as v1=0 when in_valid=0 and enable=1.
  - Simultaneous output transfer and input accept in the same cycle is legal. Throughput is one word per clock.
- Stalled output: dataout and out_valid hold stable until accepted. Data registers behind a bubble need not be cleared.
- Reset (asynchronous, mid-operation included): v1, v2 and v3 clear to 0, dataout to 0, range_err to 0, partials to 0. Any in-flight words are discarded. in_ready is high after reset because out_valid=0.
- No internal FSM beyond the valid shift chain. Pipeline occupancy is at most 3 words, and no word is ever dropped or duplicated.

Optional Feature:
- Macro: FTF_RANGE_CHECK_EN.
- When defined:
  - S3 also registers range_err = bit DATA_W of the full sum, so it is aligned with dataout.
  - range_err flags a non-codeword or corrupted input whose value is not representable.
  - range_err is valid only while out_valid=1 and holds during a stall.
- When undefined: the range_err port and its logic are absent, and overflow silently truncates.

Decomposition:
- Shared package/include: FNS.vh (FNS01..FNS43, FBLEN42, FRLENxx). Add FTF42_GRP_W = 7 and FTF42_NGRP = 6 to it.
- Natural sub-module: ftf_group_sum7. It is combinational, takes 7 code bits plus a base index, and returns their weighted sum using FNS constants. It is instantiated 6 times.

Test Plan:
- Reset, then codein=0 with in_valid=1 -> out_valid rises 3 clocks later with dataout=0; range_err=0.
- One-hot codewords, one per clock with out_ready=1:
  - bit0 -> 1
  - bit1 -> FNS02
  - bit20 -> FNS21
  - bit41 -> FNS42
  - Outputs appear back-to-back, in order, with 3-cycle latency.
- Round-trip: 10000 random values < 2^FBLEN42 through FTF_encoder_42, then this block -> dataout equals the original value on every word, and range_err is never set.
- Backpressure: stream 5 words, hold out_ready=0 for 4 clocks after the first out_valid:
  - in_ready=0 while stalled
  - dataout is stable
  - all 5 words are delivered once each, in order.
- Reset mid-stream: assert reset_n=0 with 3 words in flight -> out_valid=0 and dataout=0 immediately (asynchronously); after release, none of the old words appear.
- FTF_RANGE_CHECK_EN: codein=42'h3FF_FFFF_FFFF (all ones) -> range_err=1 with out_valid. Codeword for the value 2^FBLEN42-1 -> range_err=0.
